// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if
//   Bundles the serial line, frame-format select and received-frame outputs
//   of the UART receive framer.
//   master : drives Din/Select, observes the received-frame outputs.
//   slave  : the framer itself.
//   Signals:
//     Din       serial line, idle high, asynchronous to the clock
//     Select    frame format: [1:0] parity (01 even, 10 odd, else none),
//               [2] two stop bits
//     Dout      last received byte, held until the next frame completes
//     Valid     one-cycle strobe when Dout/ParErr/FrameErr update
//     ParErr    parity mismatch in the last frame
//     FrameErr  stop bit sampled low in the last frame
//     Reading   high from start detection until return to idle
//     dbg_state current receiver state encoding (observation only)
//   Handshake: Valid is a pure strobe with no ready/back-pressure. The
//   receiver cannot be stalled, so a consumer must capture Dout, ParErr and
//   FrameErr in the cycle Valid is high; they stay stable afterwards until
//   the next Valid.
interface uart_rx_framer_if;
  logic       Din;
  logic [2:0] Select;
  logic [7:0] Dout;
  logic       Valid;
  logic       ParErr;
  logic       FrameErr;
  logic       Reading;
  logic [2:0] dbg_state;

  modport master (
    output Din, Select,
    input  Dout, Valid, ParErr, FrameErr, Reading, dbg_state
  );

  modport slave (
    input  Din, Select,
    output Dout, Valid, ParErr, FrameErr, Reading, dbg_state
  );
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   UART receive framer with 16x oversampling, optional even/odd parity and
//   one or two stop bits. Each frame is reported with a one-cycle Valid.
//   Parameters:
//     DIV  clock cycles per oversample tick (bit period = 16*DIV), DIV >= 2
//   Ports:
//     Clk  system clock
//     Rst  asynchronous active-high reset
//     bus  uart_rx_framer_if.slave (line input, format, frame outputs)
module uart_rx_framer #(
  parameter int DIV = 27
) (
  input  logic            Clk,
  input  logic            Rst,
  uart_rx_framer_if.slave bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5,
    DONE   = 3'd6,
    BREAK  = 3'd7
  } state_t;

  state_t        state, state_next;
  logic          sync1, sync2;
  logic          s;
  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [2:0]    cfg;
  logic          par_acc;
  logic [7:0]    dout_r;
  logic          par_err_r;
  logic          frame_err_r;
  logic          tick;
  logic          mid;
  logic          par_en;
  logic          par_calc;
  logic          final_stop;

  assign s        = sync2;
  assign tick     = (div_cnt == DW'(DIV - 1));
  assign mid      = tick && (tick_cnt == 4'd7);
  assign par_en   = cfg[0] ^ cfg[1];
  // Even parity errs on odd total ones; odd parity inverts that result.
  assign par_calc = (^shreg) ^ s ^ cfg[1];
  // The stop-bit sample that ends the frame (moves the FSM into DONE).
  assign final_stop = (state == STOP1 || state == STOP2) && (state_next == DONE);

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.Din;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!s) state_next = START;
      START:  if (mid) state_next = s ? IDLE : DATA;
      DATA:   if (mid && bit_cnt == 3'd7) state_next = par_en ? PARITY : STOP1;
      PARITY: if (mid) state_next = STOP1;
      STOP1: begin
        // A low first stop bit reports immediately, skipping STOP2.
        if (mid) state_next = (s && cfg[2]) ? STOP2 : DONE;
      end
      STOP2:  if (mid) state_next = DONE;
      DONE:   state_next = (frame_err_r && !s) ? BREAK : IDLE;
      BREAK:  if (s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Counters sit at zero while idle so that the first cycle after
  // start detection always begins a fresh tick and bit-timing is fixed.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      cfg         <= '0;
      par_acc     <= 1'b0;
      dout_r      <= '0;
      par_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (state == IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_acc  <= 1'b0;
        if (!s) cfg <= bus.Select;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) tick_cnt <= tick_cnt + 4'd1;
      end

      if (state == DATA && mid) begin
        shreg   <= {s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == PARITY && mid) par_acc <= par_calc;

      // Outputs load on the last stop sample so they are already stable in
      // the DONE cycle where Valid is high. Only the final stop sample can
      // be low here: a low STOP1 never proceeds to STOP2.
      if (final_stop) begin
        dout_r      <= shreg;
        par_err_r   <= par_acc;
        frame_err_r <= ~s;
      end
    end
  end

  assign bus.Dout      = dout_r;
  assign bus.ParErr    = par_err_r;
  assign bus.FrameErr  = frame_err_r;
  assign bus.Valid     = (state == DONE);
  assign bus.Reading   = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Configurable UART receive framer for the far end of the serial link driven by the team's UART transmitter. It recovers frames from an asynchronous serial line using 16x oversampling, with optional parity and one or two stop bits. It flags parity and framing errors and presents each received byte with a one-cycle valid strobe. It is the receiver counterpart to the transmitter's configurable frame format: the same 3-bit `Select` word programs both ends.

## Interface
Parameters:
- `DIV`, default 27: clock cycles per oversample tick; bit period is 16*DIV cycles. Legal range is DIV ≥ 2.

Ports:
- `Clk` in 1: system clock.
- `Rst` in 1: asynchronous, active-high reset.
- `Din` in 1: serial line, idle high. Asynchronous to `Clk`.
- `Select` in 3: frame format.
  - [1:0] parity: 00 none, 01 even, 10 odd, 11 none.
  - [2]: 1 means two stop bits.
- `Dout` out 8: last received byte, held until the next frame completes.
- `Valid` out 1: one-cycle pulse when `Dout`/`ParErr`/`FrameErr` update.
- `ParErr` out 1: parity mismatch in the last frame. Valid with `Valid`, held after.
- `FrameErr` out 1: stop bit sampled low in the last frame. Valid with `Valid`, held after.
- `Reading` out 1: high from start detection until return to IDLE.

## Operation
- `Din` passes through a 2-flop synchronizer. Only the synchronized value `s` is used.
- Tick divider: a counter 0..DIV-1 produces `tick` when it reaches DIV-1. It is cleared on the start-detect cycle so bit timing is deterministic.
- Tick counter: 4 bits, 0..15, advanced on each `tick`. A bit is sampled when the tick counter equals 7 (mid-bit).
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK.
- IDLE: when `s`=0, latch `Select` into the frame config, clear the counters, assert `Reading`, and go to START.
  - `Select` changes during a frame have no effect on that frame.
- START: at mid-bit, if `s`=1 (glitch), return to IDLE with no `Valid`. Otherwise go to DATA.
- DATA: 8 bits, LSB first, sampled at mid-bit into a shift register.
  - Next state is PARITY if parity is enabled, else STOP1.
- PARITY: sample the parity bit.
  - Even: error if XOR(data, bit) = 1.
  - Odd: error if XOR(data, bit) = 0.
- STOP1: sample at mid-bit; low sets the frame error. Go to STOP2 if two stop bits are configured and STOP1 was high; else go to DONE.
- STOP2: sample at mid-bit; low sets the frame error. Go to DONE.
- DONE, lasting one cycle: load `Dout`, `ParErr`, `FrameErr`; pulse `Valid`.
  - If the frame error is set and `s`=0, go to BREAK. Otherwise go to IDLE.
- BREAK: wait until `s`=1, then go to IDLE.
  - A line held low produces exactly one `Valid` with `FrameErr`=1 and `Dout`=8'h00.
- A low STOP1 skips STOP2 (fast error report).
- `Reading` drops on entry to IDLE.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after DONE.

## Timing
- Reset values: `Dout`=0, `Valid`=0, `ParErr`=0, `FrameErr`=0, `Reading`=0. State is IDLE, counters are 0, synchronizer flops are 1.
- Reset mid-frame aborts immediately with no `Valid`. After release, the block waits in IDLE for a falling `s`.
- Let D be the start-detect cycle: the 2nd rising `Clk` edge after `Din` falls (synchronizer latency 2).
- Mid-sample of frame bit k (start = 0) occurs at D + 8*DIV + 16*DIV*k.
- `Valid` is high on the cycle after the final stop-bit sample. With N = frame bits including start:
  - `Valid` at D + 8*DIV + 16*DIV*(N-1) + 1.
  - For 8N1 (N=10) and DIV=4, that is D+609.
- `Reading` is high from D+1 through the `Valid` cycle inclusive, when the flow returns directly to IDLE.
- Throughput: one frame per N bit periods with no dead bit required. The tolerated baud mismatch is about ±3% for 8N1.

## Test plan
- DIV=4, `Select`=000, send 8'hA5 as 8N1 at 64 clk/bit:
  - One `Valid` at D+609.
  - `Dout`=A5, `ParErr`=0, `FrameErr`=0.
  - `Reading` high D+1..D+609.
- `Select`=001 (even), send 8'h03 with parity bit 1:
  - `ParErr`=1, `Dout`=03.
  - Repeat with parity bit 0: `ParErr`=0.
  - `Select`=010 with parity bit 1: `ParErr`=0.
- `Select`=100, send 8'h5A with second stop bit low:
  - `FrameErr`=1, `Dout`=5A.
  - `Valid` at D+8*4+16*4*10+1 = D+673.
- Glitch: `Din` low for 20 clk then high:
  - No `Valid`.
  - `Reading` pulses, then returns to 0 by D+34.
  - A following 8'h11 frame is received correctly.
- Break: hold `Din` low for 3 frame times, then release:
  - Exactly one `Valid` with `Dout`=00, `FrameErr`=1.
  - `Reading` stays high until `Din` returns high plus 2 cycles.
  - A following 8'hC3 frame is received.
- Assert `Rst` during DATA of a frame:
  - All outputs return to reset values asynchronously; no `Valid` for the aborted frame.
  - A frame started after `Rst` is released is received correctly.
- `Select` changed mid-frame:
  - The frame decodes with the format latched at start.
  - The next frame uses the new format.
